// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width, counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a.
package uart_pkg;

    // Data bits per 8N1 frame.
    localparam int UART_DATA_BITS = 8;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    // Width of a counter that must hold 0..div-1; at least one bit.
    function automatic int uart_cnt_width(input int div);
        if (div <= 2) begin
            return 1;
        end
        return $clog2(div);
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous show-ahead FIFO, 2**ADDR_W entries, wrap-bit pointers.
// Latency: a write is visible at rd_data/!empty the cycle after wr_en.
// Backpressure: writes while full are ignored unless a read frees the slot in the same cycle.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wr_en, wr_data      write request and data
//   full                no free slot (pointers differ only in the MSB)
//   rd_en, rd_data      pop request; rd_data shows the head (0 when empty)
//   empty, count        pointers equal; current occupancy 0..2**ADDR_W
module axis_sync_fifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              full,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
    logic             rd_ok;
    logic             wr_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    // Head is forced to zero when empty so the output never shows stale data.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

    // When full, a simultaneous pop frees the slot the write lands in.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q[ADDR_W-1:0]] = wr_data;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/axis_uart_rx_wrapper.sv
// 8N1 UART receiver feeding an AXI-Stream master through a 2**RX_SIZE FIFO.
// Latency: byte written to FIFO the cycle after the mid-stop sample; o_tvalid one cycle later.
// Backpressure: o_tready stalls the FIFO head; a full FIFO drops new bytes and pulses o_overrun.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   rx                  serial line (asynchronous, idle high)
//   o_tdata/o_tvalid    FIFO head and non-empty flag
//   o_tready            consumer accept
//   o_frame_err         1-cycle pulse when the stop bit is sampled low
//   o_overrun           1-cycle pulse when a good byte is dropped on a full FIFO
//   o_count             FIFO occupancy
module axis_uart_rx_wrapper
    import uart_pkg::*;
#(
    parameter int RX_SIZE   = 4,
    parameter int clkdiv_rx = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic [7:0]         o_tdata,
    output logic               o_tvalid,
    input  logic               o_tready,
    output logic               o_frame_err,
    output logic               o_overrun,
    output logic [RX_SIZE:0]   o_count
);

    localparam int CNT_W = uart_cnt_width(clkdiv_rx);
    localparam int BIT_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(clkdiv_rx - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(clkdiv_rx / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

    // Synchronizer and edge history
    logic                       rx_meta_q, rx_meta_d;
    logic                       rx_s_q, rx_s_d;
    logic                       rx_prev_q, rx_prev_d;
    logic [1:0]                 warm_q, warm_d;

    // Receiver datapath
    uart_rx_state_t             state_q, state_d;
    logic [CNT_W-1:0]           baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
    logic                       wr_req_q, wr_req_d;
    logic [UART_DATA_BITS-1:0]  wr_dat_q, wr_dat_d;
    logic                       frame_err_q, frame_err_d;

    logic                       fall_edge;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       rd_en;

    // The sync flops come out of reset high, so edge history is only trusted
    // once real line samples have reached both rx_s and rx_prev (3 cycles).
    // A line already low at reset release therefore never looks like a start.
    assign fall_edge = (warm_q == 2'd3) && rx_prev_q && !rx_s_q;

    always_comb begin
        rx_meta_d   = rx;
        rx_s_d      = rx_meta_q;
        rx_prev_d   = rx_s_q;
        warm_d      = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;

        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        wr_req_d    = 1'b0;
        wr_dat_d    = wr_dat_q;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                if (fall_edge) begin
                    state_d = START;
                end
            end

            START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (baud_cnt_q == HALF_LAST) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = rx_s_q ? IDLE : DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_ONE;
                end
            end

            DATA: begin
                if (baud_cnt_q == DIV_LAST) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
                    bit_cnt_d  = bit_cnt_q + BIT_ONE;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_ONE;
                end
            end

            STOP: begin
                // Leaving at mid-stop gives half a bit to catch a back-to-back start edge.
                if (baud_cnt_q == DIV_LAST) begin
                    baud_cnt_d = '0;
                    if (rx_s_q) begin
                        wr_req_d = 1'b1;
                        wr_dat_d = shift_q;
                        state_d  = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_ONE;
                end
            end

            BREAK: begin
                // Wait out a held-low line so it reports only one framing error.
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            warm_q      <= 2'd0;
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            wr_req_q    <= 1'b0;
            wr_dat_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            rx_prev_q   <= rx_prev_d;
            warm_q      <= warm_d;
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            wr_req_q    <= wr_req_d;
            wr_dat_q    <= wr_dat_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rd_en = o_tready && !fifo_empty;

    axis_sync_fifo #(
        .WIDTH  (UART_DATA_BITS),
        .ADDR_W (RX_SIZE)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_req_q),
        .wr_data (wr_dat_q),
        .full    (fifo_full),
        .rd_en   (rd_en),
        .rd_data (o_tdata),
        .empty   (fifo_empty),
        .count   (o_count)
    );

    assign o_tvalid    = !fifo_empty;
    assign o_frame_err = frame_err_q;
    // A pop in the same cycle frees the slot, so only a non-popping full FIFO drops.
    assign o_overrun   = wr_req_q && fifo_full && !rd_en;

endmodule

// File: doc/axis_uart_rx_wrapper.md
Name: axis_uart_rx_wrapper

Overview:
- UART receiver with an AXI-Stream master output. It is the receive-side counterpart of axis_uart_tx_wrapper.
- Frame format is 8N1: 1 start bit, 8 data bits LSB first, 1 stop bit, line idle high.
- Bit period is a fixed number of clk cycles. Good bytes are buffered in a 2**RX_SIZE-entry FIFO and presented on o_tdata/o_tvalid.
- Used on the FTDI UART_RX pin of the MDM top and in TX->RX loopback benches.

Parameters:
- RX_SIZE, 4: log2 of FIFO depth (16 entries).
- clkdiv_rx, 50: clk cycles per UART bit; legal range 4..65535. Counter width is $clog2(clkdiv_rx).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- rx  input  1  serial line, asynchronous to clk.
- o_tdata  output  8  received byte at FIFO head.
- o_tvalid  output  1  FIFO non-empty.
- o_tready  input  1  consumer accepts; a byte transfers when o_tvalid && o_tready.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_overrun  output  1  one-cycle pulse: good byte dropped because FIFO full.
- o_count  output  RX_SIZE+1  current FIFO occupancy.

Behaviour:
- Reset:
  - Asynchronous, active-high, covers every flop.
  - 2-flop synchronizer on rx resets to 1; FSM resets to IDLE; counters and FIFO pointers reset to 0.
  - Outputs during and after reset: o_tvalid=0, o_tdata=0, o_frame_err=0, o_overrun=0, o_count=0.
- Synchronizer: rx passes 2 flops (rx_s). All decisions use rx_s; edge detection uses rx_s and its previous value.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - Falling edge of rx_s (1->0): load bit counter, go START.
- START:
  - Wait clkdiv_rx/2 cycles (integer division), then sample rx_s.
  - Sample 0: clear bit counter, go DATA.
  - Sample 1: glitch; go IDLE with no flag.
- DATA:
  - Every clkdiv_rx cycles, sample rx_s into shift register, LSB first.
  - After the 8th sample, go STOP.
- STOP:
  - After clkdiv_rx cycles, sample rx_s.
  - Sample 1: byte is good; request FIFO write, go IDLE. Returning at mid-stop allows a back-to-back start edge to be caught.
  - Sample 0: pulse o_frame_err for 1 cycle, discard byte, go BREAK.
- BREAK: stay until rx_s==1, then go IDLE. A held-low line yields exactly one frame_err.
- Latency:
  - Stop sample at cycle S; FIFO write at S+1.
  - o_tvalid rises at S+2 when the FIFO was empty.
  - o_tdata is valid whenever o_tvalid=1 (show-ahead head register).
- FIFO:
  - Depth 2**RX_SIZE; pointers are RX_SIZE+1 bits with wrap bit.
  - Full when pointers differ only in the MSB; empty when equal.
- Write while full: drop the new byte, pulse o_overrun at S+1, keep stored contents.
- Read and write in the same cycle:
  - When non-empty and not full, both occur and o_count is unchanged.
  - When full, the read frees a slot and the write is accepted: no overrun, count stays 2**RX_SIZE.
  - When empty, the write lands; o_tvalid asserts next cycle.
- Stability: o_tdata/o_tvalid hold stable while o_tvalid && !o_tready.
- Reset mid-frame: the frame is abandoned and FIFO contents are lost. After release, a line already low is not treated as a start bit until a 1->0 edge is seen.

Decomposition:
- Package uart_pkg:
  - enum uart_rx_state_t {IDLE, START, DATA, STOP, BREAK}
  - UART_DATA_BITS=8
  - localparam helper for counter width.
- Sub-module axis_sync_fifo:
  - Parameters WIDTH, ADDR_W.
  - Ports clk, rst, wr_en, wr_data, full, rd_en, rd_data, empty, count.
  - Intended to be reusable by the TX wrapper.
- The FSM, synchronizer and shift register stay in axis_uart_rx_wrapper.

Test Plan:
- Single byte: clkdiv_rx=50, drive 0x55 8N1 with 50-cycle bits, o_tready=1 → exactly one o_tvalid beat with o_tdata=0x55, 2 cycles after the mid-stop sample, no flags.
- Back-to-back stream through axis_uart_tx_wrapper loopback:
  - Stimulus: 0x55,0x55,0x55,0x00,0xAA,0xFF,0x53,0xCA,0x5A,0xA5,... ending 0x18, with o_tready=1.
  - Response: identical 17-byte sequence out, in order, no frame_err/overrun.
- Backpressure/overrun:
  - Stimulus: o_tready=0, send 17 bytes 0x00..0x10.
  - Response: o_count reaches 16; 17th byte pulses o_overrun once.
  - Then raise o_tready: 0x00..0x0F drain in order.
- Framing error: send 0xA5 with stop bit 0, then hold rx low 200 cycles, then high → one o_frame_err pulse, no beat; next frame 0x3C is received correctly.
- Glitch: rx low for 10 cycles (<25) then high → no state leaves IDLE beyond START, no beat, no flags.
- Async reset: assert rst during DATA bit 4 of 0x81 → outputs 0 immediately. After release, frame 0x7E is received correctly and the aborted byte never appears.
